counter_sequencer: RTL and testbench

Command-driven controller that sequences a WIDTH-bit binary counter datapath. The datapath is held internally.
- Accepts start/stop/pause commands.
- Latches a count window (start value, end value, direction, loop mode).
- Steps the counter once per clock.
- Reports terminal count and wrap events.
- Sits between a host/test FSM and the counter output bus `out`.

---
 rtl/counter_sequencer_if.sv | 44 ++++
 rtl/counter_sequencer.sv | 147 ++++++++++++++
 tb/tb_counter_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/counter_sequencer_if.sv
// Command/config/status bundle between a host FSM and counter_sequencer.
// Defining COUNTER_SEQ_ERR_EN adds the err status line.
interface counter_sequencer_if #(
   parameter int WIDTH = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cfg_start;
   logic [WIDTH-1:0] cfg_end;
   logic             cfg_dir;
   logic             cfg_loop;
   logic [WIDTH-1:0] out;
   logic             busy;
   logic             done;
   logic             wrap;
   // Debug view of the controller state (IDLE=0, LOAD=1, RUN=2, HOLD=3).
   logic [1:0]       state;
`ifdef COUNTER_SEQ_ERR_EN
   logic             err;
`endif

   // Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
   // cmd_op and cfg_* must be stable with cmd_valid, and the host may drop cmd_valid freely.
`ifdef COUNTER_SEQ_ERR_EN
   modport master (
      output cmd_valid, cmd_op, cfg_start, cfg_end, cfg_dir, cfg_loop,
      input  cmd_ready, out, busy, done, wrap, state, err
   );
   modport slave (
      input  cmd_valid, cmd_op, cfg_start, cfg_end, cfg_dir, cfg_loop,
      output cmd_ready, out, busy, done, wrap, state, err
   );
`else
   modport master (
      output cmd_valid, cmd_op, cfg_start, cfg_end, cfg_dir, cfg_loop,
      input  cmd_ready, out, busy, done, wrap, state
   );
   modport slave (
      input  cmd_valid, cmd_op, cfg_start, cfg_end, cfg_dir, cfg_loop,
      output cmd_ready, out, busy, done, wrap, state
   );
`endif
endinterface

// File: rtl/counter_sequencer.sv
// Command-driven sequencer for a WIDTH-bit up/down counter with loop and pause.
// Optional COUNTER_SEQ_ERR_EN adds an err pulse for accepted-but-ignored commands.
module counter_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   counter_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      HOLD = 2'd3
   } state_t;

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_START = 2'b01;
   localparam logic [1:0] OP_STOP  = 2'b10;
   localparam logic [1:0] OP_PAUSE = 2'b11;

   localparam logic [WIDTH-1:0] step_one = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state, state_n;
   logic [WIDTH-1:0] cnt, cnt_n;
   logic [WIDTH-1:0] start_r, end_r;
   logic             dir_r, loop_r;
   logic             done_r, done_n;
   logic             wrap_r, wrap_n;
   logic             err_n;
   logic             latch_cfg;
   logic             accept;

   assign bus.cmd_ready = (state != LOAD);
   assign bus.busy      = (state != IDLE);
   assign bus.out       = cnt;
   assign bus.done      = done_r;
   assign bus.wrap      = wrap_r;
   assign bus.state     = state;

   assign accept = bus.cmd_valid && bus.cmd_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         start_r <= '0;
         end_r   <= '0;
         dir_r   <= 1'b0;
         loop_r  <= 1'b0;
         done_r  <= 1'b0;
         wrap_r  <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         done_r <= done_n;
         wrap_r <= wrap_n;
         if (latch_cfg) begin
            start_r <= bus.cfg_start;
            end_r   <= bus.cfg_end;
            dir_r   <= bus.cfg_dir;
            loop_r  <= bus.cfg_loop;
         end
      end
   end

`ifdef COUNTER_SEQ_ERR_EN
   logic err_r;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_r <= 1'b0;
      else     err_r <= err_n;
   end
   assign bus.err = err_r;
`endif

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      done_n    = 1'b0;
      wrap_n    = 1'b0;
      err_n     = 1'b0;
      latch_cfg = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (bus.cmd_op == OP_START) begin
                  latch_cfg = 1'b1;
                  state_n   = LOAD;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         LOAD: begin
            cnt_n   = start_r;
            state_n = RUN;
         end
         RUN: begin
            if (accept && bus.cmd_op == OP_STOP) begin
               state_n = IDLE;
            end else if (accept && bus.cmd_op == OP_START) begin
               latch_cfg = 1'b1;
               state_n   = LOAD;
            end else if (accept && bus.cmd_op == OP_PAUSE) begin
               state_n = HOLD;
            end else begin
               // A NOP in RUN is flagged but does not disturb stepping.
               err_n = accept && (bus.cmd_op == OP_NOP);
               if (cnt == end_r) begin
                  if (loop_r) begin
                     cnt_n  = start_r;
                     wrap_n = 1'b1;
                  end else begin
                     state_n = IDLE;
                     done_n  = 1'b1;
                  end
               end else if (dir_r) begin
                  cnt_n = cnt - step_one;
               end else begin
                  cnt_n = cnt + step_one;
               end
            end
         end
         HOLD: begin
            if (accept) begin
               unique case (bus.cmd_op)
                  OP_PAUSE: state_n = RUN;
                  OP_STOP:  state_n = IDLE;
                  OP_START: begin
                     latch_cfg = 1'b1;
                     state_n   = LOAD;
                  end
                  default:  err_n = 1'b1;
               endcase
            end
         end
         default: state_n = IDLE;
      endcase
   end

`ifndef COUNTER_SEQ_ERR_EN
   logic unused_err;
   assign unused_err = err_n;
`endif

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed self-checking bench for counter_sequencer (WIDTH=4).
// Inputs change 1 time unit after each rising edge; outputs are checked at that point.
module tb_counter_sequencer;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   counter_sequencer_if #(.WIDTH(4)) bus ();

   counter_sequencer #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic [1:0] op, input logic [3:0] s, input logic [3:0] e,
                      input logic d, input logic l);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cfg_start = s;
      bus.cfg_end   = e;
      bus.cfg_dir   = d;
      bus.cfg_loop  = l;
      tick();
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cfg_start = 4'd0;
      bus.cfg_end   = 4'd0;
      bus.cfg_dir   = 1'b0;
      bus.cfg_loop  = 1'b0;
      tick();
      tick();
      check("rst_out", bus.out, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_ready", bus.cmd_ready, 1);
      check("rst_done", bus.done, 0);
      check("rst_wrap", bus.wrap, 0);
      rst = 1'b0;
      tick();

      // 1: async reset in the middle of a run
      cmd(2'b01, 4'd0, 4'd15, 1'b0, 1'b0);
      check("t1_load_ready", bus.cmd_ready, 0);
      check("t1_load_busy", bus.busy, 1);
      tick();
      check("t1_first", bus.out, 0);
      for (int i = 0; i < 5; i++) tick();
      check("t1_at5", bus.out, 5);
      #2 rst = 1'b1;
      #1;
      check("t1_rst_out", bus.out, 0);
      check("t1_rst_busy", bus.busy, 0);
      check("t1_rst_ready", bus.cmd_ready, 1);
      check("t1_rst_done", bus.done, 0);
      rst = 1'b0;
      tick();
      check("t1_after_out", bus.out, 0);
      check("t1_after_done", bus.done, 0);

      // 2: up count 3..7, no loop
      cmd(2'b01, 4'd3, 4'd7, 1'b0, 1'b0);
      check("t2_hold_out", bus.out, 0);
      for (int v = 3; v <= 7; v++) begin
         tick();
         check("t2_seq", bus.out, v);
         check("t2_busy", bus.busy, 1);
         check("t2_nodone", bus.done, 0);
      end
      tick();
      check("t2_done", bus.done, 1);
      check("t2_idle_busy", bus.busy, 0);
      check("t2_hold7", bus.out, 7);
      tick();
      check("t2_done_pulse", bus.done, 0);
      check("t2_hold7b", bus.out, 7);

      // 3: down count through zero, 2..14
      cmd(2'b01, 4'd2, 4'd14, 1'b1, 1'b0);
      tick(); check("t3_a", bus.out, 2);
      tick(); check("t3_b", bus.out, 1);
      tick(); check("t3_c", bus.out, 0);
      tick(); check("t3_d", bus.out, 15);
      check("t3_nowrap", bus.wrap, 0);
      tick(); check("t3_e", bus.out, 14);
      tick();
      check("t3_done", bus.done, 1);
      check("t3_wrap", bus.wrap, 0);
      check("t3_out", bus.out, 14);

      // 4: loop 5..6 then stop
      cmd(2'b01, 4'd5, 4'd6, 1'b0, 1'b1);
      tick(); check("t4_a", bus.out, 5); check("t4_a_wrap", bus.wrap, 0);
      tick(); check("t4_b", bus.out, 6); check("t4_b_wrap", bus.wrap, 0);
      tick(); check("t4_c", bus.out, 5); check("t4_c_wrap", bus.wrap, 1);
      tick(); check("t4_d", bus.out, 6); check("t4_d_wrap", bus.wrap, 0);
      tick(); check("t4_e", bus.out, 5); check("t4_e_wrap", bus.wrap, 1);
      check("t4_nodone", bus.done, 0);
      cmd(2'b10, 4'd0, 4'd0, 1'b0, 1'b0);
      check("t4_stop_out", bus.out, 5);
      check("t4_stop_busy", bus.busy, 0);
      check("t4_stop_done", bus.done, 0);
      check("t4_stop_wrap", bus.wrap, 0);
      tick();
      check("t4_idle_out", bus.out, 5);

      // 5: pause at 4 for five cycles, then resume
      cmd(2'b01, 4'd0, 4'd15, 1'b0, 1'b0);
      for (int v = 0; v <= 4; v++) begin
         tick();
         check("t5_seq", bus.out, v);
      end
      cmd(2'b11, 4'd0, 4'd0, 1'b0, 1'b0);
      check("t5_hold_out", bus.out, 4);
      check("t5_hold_busy", bus.busy, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t5_frozen", bus.out, 4);
         check("t5_ready", bus.cmd_ready, 1);
      end
      cmd(2'b11, 4'd0, 4'd0, 1'b0, 1'b0);
      check("t5_resume_edge", bus.out, 4);
      tick(); check("t5_r5", bus.out, 5);
      tick(); check("t5_r6", bus.out, 6);
      cmd(2'b10, 4'd0, 4'd0, 1'b0, 1'b0);
      check("t5_stop", bus.out, 6);

      // 6: restart mid-run into a degenerate start==end window
      cmd(2'b01, 4'd0, 4'd9, 1'b0, 1'b0);
      for (int v = 0; v <= 3; v++) tick();
      check("t6_at3", bus.out, 3);
      cmd(2'b01, 4'd8, 4'd8, 1'b0, 1'b0);
      check("t6_load_ready", bus.cmd_ready, 0);
      check("t6_load_out", bus.out, 3);
      tick();
      check("t6_ready_back", bus.cmd_ready, 1);
      check("t6_out8", bus.out, 8);
      check("t6_nodone", bus.done, 0);
      tick();
      check("t6_done", bus.done, 1);
      check("t6_idle", bus.busy, 0);
      check("t6_hold8", bus.out, 8);
`ifdef COUNTER_SEQ_ERR_EN
      check("t6_err_quiet", bus.err, 0);
      cmd(2'b10, 4'd0, 4'd0, 1'b0, 1'b0);
      check("t6_err_pulse", bus.err, 1);
      tick();
      check("t6_err_clear", bus.err, 0);
`endif

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
